// File: rtl/dht11_emulador_pkg.sv
// Shared definitions for the DHT11 emulator and the DHT11 measurement interface:
// state codes, default timing in cycles at 50 MHz, and frame width.
package dht11_emulador_pkg;

    typedef enum logic [2:0] {
        EST_IDLE      = 3'd0,
        EST_HOST_LOW  = 3'd1,
        EST_WAIT_RESP = 3'd2,
        EST_RESP_LOW  = 3'd3,
        EST_RESP_HIGH = 3'd4,
        EST_BIT_LOW   = 3'd5,
        EST_BIT_HIGH  = 3'd6,
        EST_FIM       = 3'd7
    } estado_t;

    localparam int CICLOS_START_MIN_DEF = 900_000;
    localparam int CICLOS_ESPERA_DEF    = 1_500;
    localparam int CICLOS_RESP_DEF      = 4_000;
    localparam int CICLOS_BIT_LOW_DEF   = 2_500;
    localparam int CICLOS_BIT0_HIGH_DEF = 1_300;
    localparam int CICLOS_BIT1_HIGH_DEF = 3_500;

    localparam int LARGURA_QUADRO = 40;
    localparam int LARGURA_CONT   = 20;

endpackage

// File: rtl/dht11_checksum.sv
// DHT11 checksum: mod-256 sum of the four data bytes, with optional LSB inversion
// so a corrupted frame can be produced on purpose.
module dht11_checksum (
    input  logic [31:0] dados,
    input  logic        injeta_erro,
    output logic [7:0]  chk
);

    logic [7:0] soma;

    always_comb begin
        soma = dados[31:24] + dados[23:16] + dados[15:8] + dados[7:0];
        chk  = {soma[7:1], soma[0] ^ injeta_erro};
    end

endmodule

// File: rtl/dht11_emulador.sv
// DHT11 sensor emulator: detects the host start pulse on the open-drain bus and
// answers with the response preamble followed by the 40-bit frame, MSB first.
module dht11_emulador
    import dht11_emulador_pkg::*;
#(
    parameter int CICLOS_START_MIN = CICLOS_START_MIN_DEF,
    parameter int CICLOS_ESPERA    = CICLOS_ESPERA_DEF,
    parameter int CICLOS_RESP      = CICLOS_RESP_DEF,
    parameter int CICLOS_BIT_LOW   = CICLOS_BIT_LOW_DEF,
    parameter int CICLOS_BIT0_HIGH = CICLOS_BIT0_HIGH_DEF,
    parameter int CICLOS_BIT1_HIGH = CICLOS_BIT1_HIGH_DEF
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire         dht_bus,
    input  logic        habilita,
    input  logic [15:0] umidade,
    input  logic [15:0] temperatura,
    input  logic        injeta_erro,
    output logic        ocupado,
    output logic        pronto,
    output logic [2:0]  db_estado
);

    localparam logic [LARGURA_CONT-1:0] T_START    = LARGURA_CONT'(CICLOS_START_MIN);
    localparam logic [LARGURA_CONT-1:0] T_ESPERA   = LARGURA_CONT'(CICLOS_ESPERA - 1);
    localparam logic [LARGURA_CONT-1:0] T_RESP     = LARGURA_CONT'(CICLOS_RESP - 1);
    localparam logic [LARGURA_CONT-1:0] T_BIT_LOW  = LARGURA_CONT'(CICLOS_BIT_LOW - 1);
    localparam logic [LARGURA_CONT-1:0] T_BIT0     = LARGURA_CONT'(CICLOS_BIT0_HIGH - 1);
    localparam logic [LARGURA_CONT-1:0] T_BIT1     = LARGURA_CONT'(CICLOS_BIT1_HIGH - 1);
    localparam logic [5:0]              ULTIMO_BIT = 6'(LARGURA_QUADRO - 1);

    estado_t                    estado_q, estado_d;
    logic [LARGURA_CONT-1:0]    cont_q, cont_d;
    logic [5:0]                 bit_cnt_q, bit_cnt_d;
    logic [LARGURA_QUADRO-1:0]  quadro_q, quadro_d;
    logic                       pronto_q, pronto_d;
    logic [2:0]                 sinc_q, sinc_d;
    logic [7:0]                 chk;
    logic                       bus_baixo;
    logic                       borda_desc;
    logic                       dirige_baixo;

    dht11_checksum u_checksum (
        .dados       ({umidade, temperatura}),
        .injeta_erro (injeta_erro),
        .chk         (chk)
    );

    // sinc_q[1] is the synchronized bus; sinc_q[2] is its previous value, so a start
    // needs a fresh falling edge and the tail of our own FIM low is never mistaken for one.
    assign bus_baixo  = ~sinc_q[1];
    assign borda_desc = ~sinc_q[1] & sinc_q[2];

    assign dirige_baixo = (estado_q == EST_RESP_LOW) || (estado_q == EST_BIT_LOW) ||
                          (estado_q == EST_FIM);
    assign dht_bus      = dirige_baixo ? 1'b0 : 1'bz;
    assign ocupado      = (estado_q >= EST_WAIT_RESP);
    assign pronto       = pronto_q;
    assign db_estado    = estado_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= EST_IDLE;
            cont_q    <= '0;
            bit_cnt_q <= '0;
            quadro_q  <= '0;
            pronto_q  <= 1'b0;
            sinc_q    <= '1;
        end else begin
            estado_q  <= estado_d;
            cont_q    <= cont_d;
            bit_cnt_q <= bit_cnt_d;
            quadro_q  <= quadro_d;
            pronto_q  <= pronto_d;
            sinc_q    <= sinc_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        cont_d    = cont_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        quadro_d  = quadro_q;
        pronto_d  = 1'b0;
        sinc_d    = {sinc_q[1:0], dht_bus};

        case (estado_q)
            EST_IDLE: begin
                if (borda_desc && habilita) estado_d = EST_HOST_LOW;
            end
            EST_HOST_LOW: begin
                if (bus_baixo) begin
                    if (cont_q == '1) cont_d = cont_q;
                end else if (cont_q >= T_START) begin
                    estado_d  = EST_WAIT_RESP;
                    quadro_d  = {umidade, temperatura, chk};
                    bit_cnt_d = '0;
                end else begin
                    estado_d = EST_IDLE;
                end
            end
            EST_WAIT_RESP: if (cont_q == T_ESPERA)  estado_d = EST_RESP_LOW;
            EST_RESP_LOW:  if (cont_q == T_RESP)    estado_d = EST_RESP_HIGH;
            EST_RESP_HIGH: if (cont_q == T_RESP)    estado_d = EST_BIT_LOW;
            EST_BIT_LOW:   if (cont_q == T_BIT_LOW) estado_d = EST_BIT_HIGH;
            EST_BIT_HIGH: begin
                if (cont_q == (quadro_q[LARGURA_QUADRO-1] ? T_BIT1 : T_BIT0)) begin
                    quadro_d  = quadro_q << 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    estado_d  = (bit_cnt_q == ULTIMO_BIT) ? EST_FIM : EST_BIT_LOW;
                end
            end
            EST_FIM: begin
                if (cont_q == T_BIT_LOW) begin
                    estado_d = EST_IDLE;
                    pronto_d = 1'b1;
                end
            end
            default: estado_d = EST_IDLE;
        endcase

        if (estado_d != estado_q) cont_d = '0;
    end

endmodule

// File: tb/tb_dht11_emulador.sv
// Bench for dht11_emulador: acts as the host, decodes the bus waveform like the
// measurement interface and compares phase lengths and frame content with a model.
module tb_dht11_emulador;

    localparam int START_MIN = 900;
    localparam int ESPERA    = 15;
    localparam int RESP      = 40;
    localparam int BIT_LOW   = 25;
    localparam int BIT0      = 13;
    localparam int BIT1      = 35;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        habilita = 1'b1;
    logic        injeta_erro = 1'b0;
    logic        host_low = 1'b0;
    logic [15:0] umidade = '0;
    logic [15:0] temperatura = '0;
    logic        ocupado;
    logic        pronto;
    logic [2:0]  db_estado;
    wire         dht_bus;

    int errors = 0;
    int checks = 0;
    int pronto_cycles = 0;

    pullup (dht_bus);
    assign dht_bus = host_low ? 1'b0 : 1'bz;

    dht11_emulador #(
        .CICLOS_START_MIN (START_MIN),
        .CICLOS_ESPERA    (ESPERA),
        .CICLOS_RESP      (RESP),
        .CICLOS_BIT_LOW   (BIT_LOW),
        .CICLOS_BIT0_HIGH (BIT0),
        .CICLOS_BIT1_HIGH (BIT1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .dht_bus     (dht_bus),
        .habilita    (habilita),
        .umidade     (umidade),
        .temperatura (temperatura),
        .injeta_erro (injeta_erro),
        .ocupado     (ocupado),
        .pronto      (pronto),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (pronto === 1'b1) pronto_cycles++;

    initial begin
        #900_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected frame from the sensor's rules: data bytes then their mod-256 sum.
    function automatic logic [39:0] modeloQuadro(input logic [15:0] um, input logic [15:0] tp,
                                                 input logic err);
        int         soma;
        logic [7:0] chk;
        soma = um[15:8] + um[7:0] + tp[15:8] + tp[7:0];
        chk  = 8'(soma % 256);
        chk[0] = chk[0] ^ err;
        return {um, tp, chk};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string nome, input int atual, input int esperado, input int tol);
        checks++;
        if (atual > esperado + tol || atual < esperado - tol) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d",
                     nome, atual, atual, esperado, esperado, tol);
        end
    endtask

    task automatic applyStimulus(input int ciclos_baixo);
        tick();
        host_low = 1'b1;
        repeat (ciclos_baixo) tick();
        host_low = 1'b0;
    endtask

    task automatic measureSeg(input logic nivel, output int dur);
        dur = 1;
        while (dur < 400) begin
            tick();
            if (dht_bus !== nivel) break;
            dur++;
        end
    endtask

    task automatic receiveFrame(input logic [39:0] esperado, input int bit_troca,
                                output logic [39:0] recebido);
        int d;
        int dur;
        recebido = '0;
        d = 0;
        while (d < 200) begin
            tick();
            d++;
            if (dht_bus === 1'b0) break;
        end
        checkOutput("atraso_preambulo", d, ESPERA + 2, 1);
        if (dht_bus !== 1'b0) return;
        checkOutput("ocupado_resp", ocupado, 1, 0);
        measureSeg(1'b0, dur);
        checkOutput("resp_low", dur, RESP, 1);
        if (dur >= 400) return;
        measureSeg(1'b1, dur);
        checkOutput("resp_high", dur, RESP, 1);
        if (dur >= 400) return;
        for (int b = 0; b < 40; b++) begin
            if (b == bit_troca) temperatura = 16'h2000;
            measureSeg(1'b0, dur);
            checkOutput($sformatf("bit%0d_low", b), dur, BIT_LOW, 1);
            if (dur >= 400) return;
            measureSeg(1'b1, dur);
            checkOutput($sformatf("bit%0d_high", b), dur, esperado[39-b] ? BIT1 : BIT0, 1);
            if (dur >= 400) return;
            recebido[39-b] = (dur > (BIT0 + BIT1) / 2);
        end
        measureSeg(1'b0, dur);
        checkOutput("fim_low", dur, BIT_LOW, 1);
        checkOutput("pronto_no_fim", pronto, 1, 0);
        checkOutput("ocupado_no_fim", ocupado, 0, 0);
    endtask

    task automatic runFrame(input string nome, input logic [15:0] um, input logic [15:0] tp,
                            input logic err, input int bit_troca, output logic [39:0] recebido);
        logic [39:0] esperado;
        int          base;
        int          soma;
        logic        erro_rx;
        umidade     = um;
        temperatura = tp;
        injeta_erro = err;
        esperado    = modeloQuadro(um, tp, err);
        base        = pronto_cycles;
        applyStimulus(1000);
        receiveFrame(esperado, bit_troca, recebido);
        checkOutput({nome, "_umidade"}, recebido[39:24], esperado[39:24], 0);
        checkOutput({nome, "_temperatura"}, recebido[23:8], esperado[23:8], 0);
        checkOutput({nome, "_chk"}, recebido[7:0], esperado[7:0], 0);
        soma    = recebido[39:32] + recebido[31:24] + recebido[23:16] + recebido[15:8];
        erro_rx = ((soma % 256) != recebido[7:0]);
        checkOutput({nome, "_erro_rx"}, erro_rx, err, 0);
        repeat (3) tick();
        checkOutput({nome, "_pronto_pulsos"}, pronto_cycles - base, 1, 0);
        checkOutput({nome, "_ocupado_final"}, ocupado, 0, 0);
        injeta_erro = 1'b0;
        repeat (20) tick();
    endtask

    task automatic watchQuiet(input string nome, input int ciclos);
        int viu_baixo;
        int viu_ocupado;
        int viu_estado;
        viu_baixo = 0;
        viu_ocupado = 0;
        viu_estado = 0;
        repeat (ciclos) begin
            tick();
            if (dht_bus !== 1'b1) viu_baixo = 1;
            if (ocupado !== 1'b0) viu_ocupado = 1;
            if (db_estado !== 3'd0) viu_estado = 1;
        end
        checkOutput({nome, "_bus_solto"}, viu_baixo, 0, 0);
        checkOutput({nome, "_sem_ocupado"}, viu_ocupado, 0, 0);
        checkOutput({nome, "_sem_estado"}, viu_estado, 0, 0);
    endtask

    initial begin
        logic [39:0] r;
        int          base;
        int          quedas;
        int          cnt;
        logic        ant;

        $display("[TB] start");
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checkOutput("reset_bus", dht_bus, 1, 0);
        checkOutput("reset_ocupado", ocupado, 0, 0);
        checkOutput("reset_pronto", pronto, 0, 0);
        checkOutput("reset_estado", db_estado, 0, 0);

        runFrame("basico", 16'h3C00, 16'h1A05, 1'b0, -1, r);
        checkOutput("basico_chk_lit", r[7:0], 8'h5B, 0);
        checkOutput("basico_um_lit", r[39:24], 16'h3C00, 0);
        checkOutput("basico_tp_lit", r[23:8], 16'h1A05, 0);

        tick();
        host_low = 1'b1;
        repeat (10) tick();
        checkOutput("curto_estado_host", db_estado, 1, 0);
        repeat (490) tick();
        host_low = 1'b0;
        repeat (5) tick();
        checkOutput("curto_estado_idle", db_estado, 0, 0);
        watchQuiet("curto", 200);

        runFrame("wrap", 16'hFF00, 16'h0101, 1'b0, -1, r);
        checkOutput("wrap_chk_lit", r[7:0], 8'h01, 0);

        runFrame("erro", 16'h3C00, 16'h1A05, 1'b1, -1, r);
        checkOutput("erro_chk_lit", r[7:0], 8'h5A, 0);

        umidade     = 16'h3C00;
        temperatura = 16'h1A05;
        base        = pronto_cycles;
        applyStimulus(1000);
        quedas = 0;
        cnt    = 0;
        ant    = 1'b1;
        while (quedas < 12 && cnt < 5000) begin
            tick();
            cnt++;
            if (ant === 1'b1 && dht_bus === 1'b0) quedas++;
            ant = dht_bus;
        end
        checkOutput("reset_meio_quedas", quedas, 12, 0);
        repeat (3) tick();
        checkOutput("reset_meio_bit_low", db_estado, 5, 0);
        reset = 1'b1;
        tick();
        checkOutput("reset_meio_bus", dht_bus, 1, 0);
        checkOutput("reset_meio_estado", db_estado, 0, 0);
        checkOutput("reset_meio_ocupado", ocupado, 0, 0);
        reset = 1'b0;
        watchQuiet("pos_reset", 100);
        checkOutput("reset_meio_sem_pronto", pronto_cycles - base, 0, 0);
        runFrame("pos_reset", 16'h3C00, 16'h1A05, 1'b0, -1, r);

        runFrame("troca", 16'h3C00, 16'h1A05, 1'b0, 5, r);
        checkOutput("troca_tp_lit", r[23:8], 16'h1A05, 0);
        temperatura = 16'h1A05;

        habilita = 1'b0;
        base     = pronto_cycles;
        applyStimulus(1000);
        watchQuiet("desabilitado", 200);
        checkOutput("desabilitado_sem_pronto", pronto_cycles - base, 0, 0);
        habilita = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
